// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with registered sync, display enable, coordinates and colour.
// Define VGA_BORDER_EN to force a one-pixel all-ones frame around the active area.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 4,
  parameter int CNT_W    = 11,
  parameter int PIX_DIV  = 1,
  parameter int CHK_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] ext_r,
  input  logic [COLOR_W-1:0] ext_g,
  input  logic [COLOR_W-1:0] ext_b,
  output logic [CNT_W-1:0]   req_x,
  output logic [CNT_W-1:0]   req_y,
  output logic [COLOR_W-1:0] VGA_RED,
  output logic [COLOR_W-1:0] VGA_GREEN,
  output logic [COLOR_W-1:0] VGA_BLUE,
  output logic               VGA_HSYNC,
  output logic               VGA_VSYNC,
  output logic               de,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ACT     = 1'(HS_POL);
  localparam logic             VS_ACT     = 1'(VS_POL);

  typedef enum logic [1:0] {
    PAT_EXT     = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_WHITE   = 2'd3
  } pattern_t;

  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  pattern_t           mode_q;
  logic               tick;
  logic               active;
  logic               in_hsync;
  logic               in_vsync;
  logic [2:0]         bar_idx;
  logic [2:0]         bar_col;
  logic               chk_white;
  logic [COLOR_W-1:0] r_d;
  logic [COLOR_W-1:0] g_d;
  logic [COLOR_W-1:0] b_d;

  assign tick  = (div_cnt == DIV_LAST);
  assign req_x = h_cnt;
  assign req_y = v_cnt;

  // Pattern selection only changes at the first pixel of a frame so a frame is never mixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      mode_q  <= PAT_EXT;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        if (h_cnt == '0 && v_cnt == '0)
          mode_q <= pattern_t'(mode);
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // Bar index found by comparing against ceil(k*H_ACTIVE/8), avoiding a divider.
  always_comb begin
    active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    in_hsync = (h_cnt >= HS_START) && (h_cnt < HS_END);
    in_vsync = (v_cnt >= VS_START) && (v_cnt < VS_END);
    bar_idx  = '0;
    for (int k = 1; k < 8; k++)
      if (h_cnt >= CNT_W'((k * H_ACTIVE + 7) / 8))
        bar_idx = 3'(k);
    bar_col   = 3'd7 - bar_idx;
    chk_white = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];
    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (mode_q)
      PAT_EXT: begin
        r_d = ext_r;
        g_d = ext_g;
        b_d = ext_b;
      end
      PAT_BARS: begin
        r_d = {COLOR_W{bar_col[2]}};
        g_d = {COLOR_W{bar_col[1]}};
        b_d = {COLOR_W{bar_col[0]}};
      end
      PAT_CHECKER: begin
        r_d = {COLOR_W{chk_white}};
        g_d = {COLOR_W{chk_white}};
        b_d = {COLOR_W{chk_white}};
      end
      PAT_WHITE: begin
        r_d = '1;
        g_d = '1;
        b_d = '1;
      end
      default: ;
    endcase
`ifdef VGA_BORDER_EN
    if (h_cnt == '0 || h_cnt == H_ACT_LAST || v_cnt == '0 || v_cnt == V_ACT_LAST) begin
      r_d = '1;
      g_d = '1;
      b_d = '1;
    end
`endif
    if (!active) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // Output stage: everything presented to the pins is one clock behind the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b0;
      VGA_RED     <= '0;
      VGA_GREEN   <= '0;
      VGA_BLUE    <= '0;
      VGA_HSYNC   <= ~HS_ACT;
      VGA_VSYNC   <= ~VS_ACT;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      de          <= active;
      VGA_RED     <= r_d;
      VGA_GREEN   <= g_d;
      VGA_BLUE    <= b_d;
      VGA_HSYNC   <= in_hsync ? HS_ACT : ~HS_ACT;
      VGA_VSYNC   <= in_vsync ? VS_ACT : ~VS_ACT;
      pix_x       <= h_cnt;
      pix_y       <= v_cnt;
      frame_start <= (h_cnt == '0) && (v_cnt == '0) && (div_cnt == '0);
    end
  end

endmodule
